// File: rtl/fetch_stage.sv
// fetch_stage: MIPS F stage. Holds the fetch PC, selects the next PC from
// redirects resolved in D, and owns the F/D pipeline register. The branch
// delay slot is always executed, so nothing here ever flushes.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [31:0]      f_instr,
  output logic [31:0]      f_pc,
  input  logic             d_beq,
  input  logic             d_cmp_eq,
  input  logic             d_j,
  input  logic             d_jal,
  input  logic             d_jr,
  input  logic [31:0]      d_rs_val,
  output logic [31:0]      d_instr,
  output logic [31:0]      d_pc,
  output logic [31:0]      d_pc8,
  output logic             d_valid,
  output logic [CNT_W-1:0] stall_cycles
);

  logic [31:0] npc;
  logic [31:0] d_pc4;
  logic [31:0] f_pc4;
  logic [31:0] br_off;

  assign d_pc4  = d_pc + 32'd4;
  assign d_pc8  = d_pc + 32'd8;
  assign f_pc4  = f_pc + 32'd4;
  assign br_off = {{14{d_instr[15]}}, d_instr[15:0], 2'b00};

  // Next-PC select; a reset bubble in D cannot redirect, and jr beats j/jal beats beq.
  always_comb begin
    // NOTE: npc gets its fall-through value first so every path assigns it
    // and no latch is inferred.
    npc = f_pc4;
    if (d_valid) begin
      if (d_jr) begin
        npc = {d_rs_val[31:2], 2'b00};
      end else if (d_j || d_jal) begin
        npc = {d_pc4[31:28], d_instr[25:0], 2'b00};
      end else if (d_beq && d_cmp_eq) begin
        npc = d_pc4 + br_off;
      end
    end
  end

  // PC and F/D register advance together on unstalled edges; a stall freezes both.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_pc    <= PC_RESET;
      d_instr <= 32'h0000_0000;
      d_pc    <= PC_RESET;
      d_valid <= 1'b0;
    end else if (!stall) begin
      // NOTE: non-blocking assignments let d_pc capture the old f_pc while
      // f_pc takes npc on the same edge.
      f_pc    <= npc;
      d_instr <= f_instr;
      d_pc    <= f_pc;
      d_valid <= 1'b1;
    end
  end

  // Saturating count of stalled edges for performance monitoring.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven check of fetch_stage with a combinational
// instruction memory model and an expected-result queue per clock edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] f_instr;
  logic [31:0] f_pc;
  logic        d_beq, d_cmp_eq, d_j, d_jal, d_jr;
  logic [31:0] d_rs_val;
  logic [31:0] d_instr, d_pc, d_pc8;
  logic        d_valid;
  logic [15:0] stall_cycles;
  logic        corrupt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        stall;
    logic        corrupt;
    logic        beq;
    logic        cmp;
    logic        j;
    logic        jal;
    logic        jr;
    logic [31:0] rs;
    logic [31:0] e_f_pc;
    logic [31:0] e_d_instr;
    logic [31:0] e_d_pc;
    logic        e_d_valid;
    logic [31:0] e_d_pc8;
    logic [15:0] e_sc;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[];

  fetch_stage #(.PC_RESET(32'h0000_3000), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .f_instr(f_instr), .f_pc(f_pc),
    .d_beq(d_beq), .d_cmp_eq(d_cmp_eq), .d_j(d_j), .d_jal(d_jal), .d_jr(d_jr),
    .d_rs_val(d_rs_val), .d_instr(d_instr), .d_pc(d_pc), .d_pc8(d_pc8),
    .d_valid(d_valid), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Instruction memory: a few fixed words, everything else tagged by address.
  function automatic logic [31:0] im(input logic [31:0] a);
    case (a)
      32'h0000_3000: im = 32'h3C01_1234;
      32'h0000_3004: im = 32'h3421_0001;
      32'h0000_3010: im = 32'h1022_FFFC;
      32'h0000_3020: im = 32'h0C00_0C10;
      default:       im = {16'h2000, a[15:0]};
    endcase
  endfunction

  assign f_instr = corrupt ? 32'hDEAD_BEEF : im(f_pc);

  function automatic vec_t mk(input logic s, input logic c, input logic b,
                              input logic eq, input logic j, input logic jl,
                              input logic jr, input logic [31:0] rs,
                              input logic [31:0] fp, input logic [31:0] di,
                              input logic [31:0] dp, input logic dv,
                              input logic [31:0] p8, input logic [15:0] sc);
    vec_t v;
    v.stall = s; v.corrupt = c; v.beq = b; v.cmp = eq; v.j = j; v.jal = jl;
    v.jr = jr; v.rs = rs; v.e_f_pc = fp; v.e_d_instr = di; v.e_d_pc = dp;
    v.e_d_valid = dv; v.e_d_pc8 = p8; v.e_sc = sc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " f_pc"},    f_pc, 32'h0000_3000);
    check({tag, " d_instr"}, d_instr, 32'h0);
    check({tag, " d_pc"},    d_pc, 32'h0000_3000);
    check({tag, " d_valid"}, {31'b0, d_valid}, 32'h0);
    check({tag, " d_pc8"},   d_pc8, 32'h0000_3008);
    check({tag, " stall_cycles"}, {16'b0, stall_cycles}, 32'h0);
  endtask

  // Drive one vector, queue its expectation, compare after the next edge.
  task automatic apply(input string tag, input vec_t v);
    vec_t e;
    stall = v.stall; corrupt = v.corrupt; d_beq = v.beq; d_cmp_eq = v.cmp;
    d_j = v.j; d_jal = v.jal; d_jr = v.jr; d_rs_val = v.rs;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'h1, 32'h0);
    end else begin
      e = sb.pop_front();
      check({tag, " f_pc"},    f_pc, e.e_f_pc);
      check({tag, " d_instr"}, d_instr, e.e_d_instr);
      check({tag, " d_pc"},    d_pc, e.e_d_pc);
      check({tag, " d_valid"}, {31'b0, d_valid}, {31'b0, e.e_d_valid});
      check({tag, " d_pc8"},   d_pc8, e.e_d_pc8);
      check({tag, " stall_cycles"}, {16'b0, stall_cycles}, {16'b0, e.e_sc});
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; corrupt = 1'b0;
    d_beq = 1'b0; d_cmp_eq = 1'b0; d_j = 1'b0; d_jal = 1'b0; d_jr = 1'b0;
    d_rs_val = 32'h0;

    tbl = new[24];
    //             stl cor beq eq  j  jal jr  rs            f_pc          d_instr       d_pc          v  d_pc8         sc
    tbl[0]  = mk(0, 0, 0, 0, 1, 0, 0, 32'h0,       32'h3004, 32'h3C011234, 32'h3000, 1, 32'h3008, 16'd0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,       32'h3008, 32'h34210001, 32'h3004, 1, 32'h300C, 16'd0);
    tbl[2]  = mk(1, 1, 0, 0, 0, 0, 0, 32'h0,       32'h3008, 32'h34210001, 32'h3004, 1, 32'h300C, 16'd1);
    tbl[3]  = mk(1, 1, 0, 0, 0, 0, 0, 32'h0,       32'h3008, 32'h34210001, 32'h3004, 1, 32'h300C, 16'd2);
    tbl[4]  = mk(1, 1, 0, 0, 0, 0, 0, 32'h0,       32'h3008, 32'h34210001, 32'h3004, 1, 32'h300C, 16'd3);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,       32'h300C, 32'h20003008, 32'h3008, 1, 32'h3010, 16'd3);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,       32'h3010, 32'h2000300C, 32'h300C, 1, 32'h3014, 16'd3);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,       32'h3014, 32'h1022FFFC, 32'h3010, 1, 32'h3018, 16'd3);
    tbl[8]  = mk(0, 0, 1, 1, 0, 0, 0, 32'h0,       32'h3004, 32'h20003014, 32'h3014, 1, 32'h301C, 16'd3);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,       32'h3008, 32'h34210001, 32'h3004, 1, 32'h300C, 16'd3);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,       32'h300C, 32'h20003008, 32'h3008, 1, 32'h3010, 16'd3);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,       32'h3010, 32'h2000300C, 32'h300C, 1, 32'h3014, 16'd3);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,       32'h3014, 32'h1022FFFC, 32'h3010, 1, 32'h3018, 16'd3);
    tbl[13] = mk(0, 0, 1, 0, 0, 0, 0, 32'h0,       32'h3018, 32'h20003014, 32'h3014, 1, 32'h301C, 16'd3);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,       32'h301C, 32'h20003018, 32'h3018, 1, 32'h3020, 16'd3);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,       32'h3020, 32'h2000301C, 32'h301C, 1, 32'h3024, 16'd3);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,       32'h3024, 32'h0C000C10, 32'h3020, 1, 32'h3028, 16'd3);
    tbl[17] = mk(0, 0, 0, 0, 0, 1, 0, 32'h0,       32'h3040, 32'h20003024, 32'h3024, 1, 32'h302C, 16'd3);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 1, 32'h3047,    32'h3044, 32'h20003040, 32'h3040, 1, 32'h3048, 16'd3);
    tbl[19] = mk(0, 0, 1, 1, 0, 0, 1, 32'h3100,    32'h3100, 32'h20003044, 32'h3044, 1, 32'h304C, 16'd3);
    tbl[20] = mk(1, 1, 0, 0, 0, 0, 1, 32'h3200,    32'h3100, 32'h20003044, 32'h3044, 1, 32'h304C, 16'd4);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 1, 32'h3200,    32'h3200, 32'h20003100, 32'h3100, 1, 32'h3108, 16'd4);
    tbl[22] = mk(0, 0, 0, 0, 1, 0, 0, 32'h0,       32'h0000C400, 32'h20003200, 32'h3200, 1, 32'h3208, 16'd4);
    tbl[23] = mk(1, 1, 0, 0, 0, 0, 0, 32'h0,       32'h0000C400, 32'h20003200, 32'h3200, 1, 32'h3208, 16'd5);

    #2;
    check_reset_state("reset");
    #5 reset = 1'b0;    // t=7, clear of the first edge

    foreach (tbl[i]) apply($sformatf("v%0d", i), tbl[i]);

    // Asynchronous reset between edges while stalled with a count of 5.
    stall = 1'b1; corrupt = 1'b1;
    #2;
    check("pre_reset stall_cycles", {16'b0, stall_cycles}, 32'd5);
    reset = 1'b1;
    #1;
    check_reset_state("async_reset");
    @(posedge clk); #1;
    check_reset_state("reset_held_edge");
    reset = 1'b0;

    // Wraparound of f_pc and d_pc8 through a jr to the top of memory.
    apply("w0", mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h3004, 32'h3C011234, 32'h3000, 1, 32'h3008, 16'd0));
    apply("w1", mk(0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h34210001, 32'h3004, 1, 32'h300C, 16'd0));
    apply("w2", mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0, 32'h2000FFFC, 32'hFFFFFFFC, 1, 32'h4, 16'd0));
    apply("w3", mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h4, 32'h20000000, 32'h0, 1, 32'h8, 16'd0));

    // Drive the counter to all-ones, then confirm it saturates.
    stall = 1'b1; corrupt = 1'b1;
    for (int n = 0; n < 65535; n++) @(posedge clk);
    #1;
    check("sat reach stall_cycles", {16'b0, stall_cycles}, 32'h0000_FFFF);
    repeat (2) @(posedge clk);
    #1;
    check("sat hold stall_cycles", {16'b0, stall_cycles}, 32'h0000_FFFF);
    check("sat hold f_pc", f_pc, 32'h4);
    check("sat hold d_instr", d_instr, 32'h20000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- F stage of the 5-stage MIPS pipeline: PC register, next-PC selection, and the F/D pipeline register feeding the instruction decoder in D.
- Redirects (beq/j/jal/jr) are resolved in D using decoder class outputs and the forwarded rs value.
- Branch-delay-slot architecture, so there is never a flush.
- Instruction memory is external and combinational: address in, word out the same cycle.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- stall  input  1  from hazard unit; freeze PC and F/D register
- f_instr  input  32  instruction word returned by IM for f_pc
- f_pc  output  32  current fetch PC, drives IM address
- d_beq  input  1  D-stage instruction is beq (decoder)
- d_cmp_eq  input  1  forwarded rs == rt in D
- d_j  input  1  D-stage instruction is j
- d_jal  input  1  D-stage instruction is jal
- d_jr  input  1  D-stage instruction is jr
- d_rs_val  input  32  forwarded rs value in D
- d_instr  output  32  F/D register: instruction
- d_pc  output  32  F/D register: PC of d_instr
- d_pc8  output  32  d_pc + 8 (jal link value)
- d_valid  output  1  F/D holds a fetched instruction (0 = reset bubble)
- stall_cycles  output  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (async, immediate, regardless of clk or stall):
  - f_pc = PC_RESET.
  - d_instr = 0 (nop), d_pc = PC_RESET, d_valid = 0.
  - stall_cycles = 0.
- d_pc8 is combinational d_pc + 8, modulo 2^32.
- Redirect decode:
  - Redirects take effect only when d_valid = 1; while d_valid = 0 all d_* class inputs are ignored.
  - The decoder guarantees at most one of d_beq/d_j/d_jal/d_jr is high. If several are high, priority is jr > j/jal > beq.
- npc selection:
  - jr: {d_rs_val[31:2], 2'b00}. Low bits are silently cleared; no exception.
  - j or jal: {d_pc4[31:28], d_instr[25:0], 2'b00}, where d_pc4 = d_pc + 4.
  - beq with d_cmp_eq = 1: d_pc4 + (sign_extend(d_instr[15:0]) << 2), 32-bit wraparound.
  - beq with d_cmp_eq = 0, or no redirect: f_pc + 4, 32-bit wraparound (0xFFFF_FFFC -> 0).
- Each rising edge with stall = 0:
  - f_pc <= npc.
  - d_instr <= f_instr, d_pc <= f_pc, d_valid <= 1.
  - The instruction fetched in the redirect cycle is the delay slot and enters D normally.
- Each rising edge with stall = 1:
  - f_pc, d_instr, d_pc and d_valid hold.
  - A redirect pending in D is not taken. The hazard unit keeps stall high until operands are ready, and the redirect is taken on the first unstalled edge.
  - stall_cycles increments by 1, saturating at all-ones (no wrap).
- Latency:
  - Instruction at f_pc appears on d_instr one edge later.
  - A redirect resolved in D sets f_pc to the target on the same edge that latches the delay slot into D.
- Reset mid-stall or mid-redirect: reset wins; state is as above with no partial update.
- f_instr is sampled only on unstalled edges; X on f_instr during stall must not propagate.

Test Plan:
- Reset release, stall = 0, IM returns 0x3C01_1234 at 0x3000 and 0x3421_0001 at 0x3004 -> f_pc goes 0x3000, 0x3004, 0x3008; d_instr = 0x3C01_1234 / d_pc = 0x3000 / d_valid = 1 after edge 1; d_pc8 = 0x3008.
- Stall held 3 cycles at f_pc = 0x3008 -> f_pc, d_instr and d_pc unchanged; stall_cycles = 3; fetch resumes to 0x300C on release.
- beq in D at d_pc = 0x3010, imm = 0xFFFC, d_cmp_eq = 1 -> next f_pc = 0x3004, delay slot (from 0x3014) latched into D. Repeat with d_cmp_eq = 0 -> next f_pc = 0x3018.
- jal at d_pc = 0x3020, index = 0x0000C10 -> f_pc = 0x0000_3040, d_pc8 = 0x3028. jr with d_rs_val = 0x0000_3047 -> f_pc = 0x3044.
- d_jr = 1 and d_beq = 1 with d_cmp_eq = 1 simultaneously, d_rs_val = 0x3100 -> f_pc = 0x3100 (jr priority). d_j = 1 while d_valid = 0 after reset -> ignored, f_pc = 0x3004.
- Assert reset asynchronously between edges during a stall with stall_cycles = 5 -> f_pc = 0x3000, d_valid = 0, stall_cycles = 0 immediately, before the next edge. Force stall_cycles to all-ones, stall 2 more cycles -> stays all-ones.
